// File: rtl/demux_16_capture_if.sv
// Bus bundle between the 16-way demux/scan-capture block and its driver.
// The slave side is the capture block; the master side drives the inputs.
interface demux_16_capture_if;
    logic        input_line;
    logic [3:0]  select_lines;
    logic        load;
    logic [15:0] output_lines;
    logic        start;
    logic [3:0]  scan_sel;
    logic        busy;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ack;

    modport slave (
        input  input_line, select_lines, load, start, word_ack,
        output output_lines, scan_sel, busy, word_out, word_valid
    );

    modport master (
        output input_line, select_lines, load, start, word_ack,
        input  output_lines, scan_sel, busy, word_out, word_valid
    );
endinterface

// File: rtl/demux_16_capture.sv
// Registered 1:16 demux plus a scan engine that sweeps an upstream 16:1 mux and deserialises its output.
// Latency: demux 1 cycle; captured word valid 16 cycles after start is accepted.
// Backpressure: word_valid holds the word until word_ack; start is dropped unless the engine is idle.
module demux_16_capture #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_16_capture_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   scan_sel_q;
    logic               busy_q;
    logic [N-1:1]       shadow_q;
    logic [N-1:0]       word_q;
    logic               word_vld_q;
    logic [N-1:0]       output_lines_q;
    logic [N-1:0]       output_lines_d;

    // Demux bank runs regardless of the scan FSM.
    always_comb begin
        output_lines_d = output_lines_q;
        if (bus.load) begin
            output_lines_d[bus.select_lines] = bus.input_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_lines_q <= '0;
        end else begin
            output_lines_q <= output_lines_d;
        end
    end

    // Bit 0 goes straight from input_line into the word, so the shadow only keeps bits 15..1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            scan_sel_q <= '0;
            busy_q     <= 1'b0;
            shadow_q   <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_SCAN;
                        cnt_q      <= {SEL_W{1'b1}};
                        scan_sel_q <= {SEL_W{1'b1}};
                        busy_q     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q != '0) begin
                        shadow_q[cnt_q] <= bus.input_line;
                        cnt_q           <= cnt_q - 1'b1;
                        scan_sel_q      <= cnt_q - 1'b1;
                    end else begin
                        word_q     <= {shadow_q, bus.input_line};
                        word_vld_q <= 1'b1;
                        busy_q     <= 1'b0;
                        scan_sel_q <= '0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.word_ack) begin
                        word_vld_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.output_lines = output_lines_q;
    assign bus.scan_sel     = scan_sel_q;
    assign bus.busy         = busy_q;
    assign bus.word_out     = word_q;
    assign bus.word_valid   = word_vld_q;

endmodule

// File: tb/tb_demux_16_capture.sv
// Directed bench: demux writes, two scan captures against a modelled upstream mux, handshake and reset abort.
module tb_demux_16_capture;

    logic        clk;
    logic        rst_n;
    logic        mux_mode;
    logic        tb_line;
    logic [15:0] up_pat;
    int          n_chk;
    int          n_bad;

    demux_16_capture_if bus ();

    demux_16_capture #(.N(16), .SEL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Upstream 16:1 mux model: combinational from scan_sel within the same cycle.
    assign bus.input_line = mux_mode ? up_pat[bus.scan_sel] : tb_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(input logic [15:0] pat, input bit poke);
        up_pat    = pat;
        mux_mode  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("scan_busy_e0", 32'(bus.busy), 32'd1);
        chk("scan_sel_e0", 32'(bus.scan_sel), 32'd15);
        chk("scan_vld_e0", 32'(bus.word_valid), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (poke && i == 6) begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
                chk("scan_load_bank", 32'(bus.output_lines), 32'h8020);
            end
            if (poke && i == 5) begin
                bus.start        = 1'b1;
                bus.load         = 1'b1;
                bus.select_lines = 4'd5;
            end
            if (i < 16) begin
                chk("scan_sel_seq", 32'(bus.scan_sel), 32'(15 - i));
                chk("scan_vld_low", 32'(bus.word_valid), 32'd0);
            end else begin
                chk("scan_vld_high", 32'(bus.word_valid), 32'd1);
                chk("scan_word", 32'(bus.word_out), 32'(pat));
                chk("scan_busy_end", 32'(bus.busy), 32'd0);
                chk("scan_sel_end", 32'(bus.scan_sel), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        n_chk            = 0;
        n_bad            = 0;
        rst_n            = 1'b0;
        mux_mode         = 1'b0;
        tb_line          = 1'b0;
        up_pat           = 16'h0000;
        bus.select_lines = 4'd0;
        bus.load         = 1'b0;
        bus.start        = 1'b0;
        bus.word_ack     = 1'b0;
        repeat (3) tick();
        chk("rst_lines", 32'(bus.output_lines), 32'h0);
        chk("rst_word", 32'(bus.word_out), 32'h0);
        chk("rst_vld", 32'(bus.word_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sel", 32'(bus.scan_sel), 32'd0);
        rst_n = 1'b1;
        tick();

        // Demux writes
        bus.load = 1'b1; bus.select_lines = 4'd3; tb_line = 1'b1;
        tick();
        chk("demux_w3", 32'(bus.output_lines), 32'h0008);
        bus.select_lines = 4'd15; tb_line = 1'b1;
        tick();
        chk("demux_w15", 32'(bus.output_lines), 32'h8008);
        bus.select_lines = 4'd3; tb_line = 1'b0;
        tick();
        chk("demux_clr3", 32'(bus.output_lines), 32'h8000);
        bus.load = 1'b0; bus.select_lines = 4'd7; tb_line = 1'b1;
        tick();
        chk("demux_hold", 32'(bus.output_lines), 32'h8000);

        // Capture 1 then acknowledge
        do_scan(16'hAAAA, 1'b0);
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        chk("ack1_vld", 32'(bus.word_valid), 32'd0);
        chk("ack1_word_kept", 32'(bus.word_out), 32'hAAAA);
        chk("ack1_busy", 32'(bus.busy), 32'd0);

        // Capture 2 with a start pulse and a demux load mid-scan
        do_scan(16'h5555, 1'b1);

        // Stall in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_vld", 32'(bus.word_valid), 32'd1);
            chk("hold_word", 32'(bus.word_out), 32'h5555);
        end

        // start together with ack: ack taken, start dropped
        bus.start = 1'b1; bus.word_ack = 1'b1;
        tick();
        bus.start = 1'b0; bus.word_ack = 1'b0;
        chk("sa_vld", 32'(bus.word_valid), 32'd0);
        chk("sa_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        chk("sa_no_scan_busy", 32'(bus.busy), 32'd0);
        chk("sa_no_scan_sel", 32'(bus.scan_sel), 32'd0);

        // Abort: reset mid-cycle after 8 scan edges
        up_pat    = 16'hFFFF;
        mux_mode  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        chk("abort_pre_sel", 32'(bus.scan_sel), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_lines", 32'(bus.output_lines), 32'h0);
        chk("abort_word", 32'(bus.word_out), 32'h0);
        chk("abort_vld", 32'(bus.word_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sel", 32'(bus.scan_sel), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("abort_after_vld", 32'(bus.word_valid), 32'd0);
        chk("abort_after_word", 32'(bus.word_out), 32'h0);
        chk("abort_after_busy", 32'(bus.busy), 32'd0);

        // Engine must be idle and clean after the abort
        do_scan(16'hFFFF, 1'b0);
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        chk("final_vld", 32'(bus.word_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
